// File: rtl/bt656_pkg.sv
// Shared constants and helpers for the BT.656 receive path: FSM codes,
// timing-reference byte values and XY-word field positions.
package bt656_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_DATA   = 2'd0;
    localparam state_t S_FF     = 2'd1;
    localparam state_t S_FF00   = 2'd2;
    localparam state_t S_FF0000 = 2'd3;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int XY_ONE = 7;
    localparam int XY_F   = 6;
    localparam int XY_V   = 5;
    localparam int XY_H   = 4;
    localparam int XY_P3  = 3;
    localparam int XY_P2  = 2;
    localparam int XY_P1  = 1;
    localparam int XY_P0  = 0;

    // True when the fixed bit is set and all four protection bits agree with F/V/H.
    function automatic logic xy_ok(input logic [7:0] xy);
        return xy[XY_ONE]
            && (xy[XY_P3] == (xy[XY_V] ^ xy[XY_H]))
            && (xy[XY_P2] == (xy[XY_F] ^ xy[XY_H]))
            && (xy[XY_P1] == (xy[XY_F] ^ xy[XY_V]))
            && (xy[XY_P0] == (xy[XY_F] ^ xy[XY_V] ^ xy[XY_H]));
    endfunction

endpackage

// File: rtl/bt656_rx_decoder.sv
// BT.656 byte-stream decoder: finds FF 00 00 XY timing references, tracks
// lock/field/line timing and turns Cb Y0 Cr Y1 groups into per-pixel YCbCr.
module bt656_rx_decoder
    import bt656_pkg::*;
#(
    parameter int H_ACTIVE   = 720,
    parameter int LOCK_LINES = 4,
    parameter int X_W        = 10,
    parameter int LINE_W     = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_y,
    output logic [7:0]        o_cb,
    output logic [7:0]        o_cr,
    output logic              o_valid,
    output logic [X_W-1:0]    o_x,
    output logic [LINE_W-1:0] o_line,
    output logic              o_field,
    output logic              o_sof,
    output logic              o_locked,
    output logic              o_err
);

    localparam int                LOCK_W   = $clog2(LOCK_LINES + 1);
    localparam logic [X_W-1:0]    X_END    = X_W'(H_ACTIVE);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_LINES);

    state_t              state;
    logic [1:0]          phase;
    logic                line_active;
    logic                prev_sav_v;
    logic                sof_armed;
    logic [7:0]          cb_q;
    logic [7:0]          y0_q;
    logic [7:0]          cr_q;
    logic [X_W-1:0]      x_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic [LOCK_W-1:0]   lock_cnt;

    logic                xy_bad;
    logic                eav;
    logic                sav;
    logic                sync_start;
    logic                pix_byte;
    logic                pix_emit;
    logic                pix_fire;
    logic [7:0]          pix_y;
    logic [7:0]          pix_cr;

    assign xy_bad     = (state == S_FF0000) && !xy_ok(i_data);
    assign eav        = (state == S_FF0000) &&  xy_ok(i_data) &&  i_data[XY_H];
    assign sav        = (state == S_FF0000) &&  xy_ok(i_data) && !i_data[XY_H];
    assign sync_start = (state == S_DATA) && (i_data == TRS_FF);
    assign pix_byte   = (state == S_DATA) && (i_data != TRS_FF) && line_active;

    // Phases 2 (Cr) and 3 (Y1) each complete one pixel of the pair.
    assign pix_emit   = pix_byte && phase[1];
    assign pix_fire   = pix_emit && o_locked && (x_cnt < X_END);
    assign pix_y      = phase[0] ? i_data : y0_q;
    assign pix_cr     = phase[0] ? cr_q   : i_data;

    // NOTE: every register here uses non-blocking assignments so all blocks
    // see the pre-edge values; the reset is synchronous, sampled on the clock.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_DATA;
            o_err <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                S_DATA:   if (i_data == TRS_FF) state <= S_FF;
                S_FF: begin
                    if (i_data == TRS_00) begin
                        state <= S_FF00;
                    end else begin
                        state <= S_DATA;
                        o_err <= 1'b1;
                    end
                end
                S_FF00: begin
                    if (i_data == TRS_00) begin
                        state <= S_FF0000;
                    end else begin
                        state <= S_DATA;
                        o_err <= 1'b1;
                    end
                end
                S_FF0000: begin
                    state <= S_DATA;
                    o_err <= xy_bad;
                end
                default:  state <= S_DATA;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            line_active <= 1'b0;
            prev_sav_v  <= 1'b0;
            sof_armed   <= 1'b0;
            line_cnt    <= '0;
            lock_cnt    <= '0;
            o_locked    <= 1'b0;
            o_field     <= 1'b0;
        end else begin
            if (xy_bad) begin
                lock_cnt <= '0;
                o_locked <= 1'b0;
            end
            if (sync_start) line_active <= 1'b0;
            if (eav) begin
                line_active <= 1'b0;
                if (!prev_sav_v)           line_cnt <= line_cnt + 1'b1;
                if (lock_cnt != LOCK_MAX)  lock_cnt <= lock_cnt + 1'b1;
                if (lock_cnt >= LOCK_MAX - 1'b1) o_locked <= 1'b1;
            end
            if (sav) begin
                o_field     <= i_data[XY_F];
                prev_sav_v  <= i_data[XY_V];
                line_active <= !i_data[XY_V];
                // First active line after vertical blanking restarts the field.
                if (!i_data[XY_V] && prev_sav_v) begin
                    line_cnt  <= '0;
                    sof_armed <= !i_data[XY_F];
                end
            end
            if (pix_fire) sof_armed <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase   <= 2'd0;
            cb_q    <= '0;
            y0_q    <= '0;
            cr_q    <= '0;
            x_cnt   <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_y     <= '0;
            o_cb    <= '0;
            o_cr    <= '0;
            o_x     <= '0;
            o_line  <= '0;
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;

            if (sav && !i_data[XY_V]) phase <= 2'd0;
            else if (pix_byte)        phase <= phase + 2'd1;

            if (pix_byte) begin
                case (phase)
                    2'd0:    cb_q <= i_data;
                    2'd1:    y0_q <= i_data;
                    2'd2:    cr_q <= i_data;
                    default: ;
                endcase
            end

            // x saturates at H_ACTIVE so overflow pixels stay gated until EAV.
            if (eav)                              x_cnt <= '0;
            else if (pix_emit && (x_cnt < X_END)) x_cnt <= x_cnt + 1'b1;

            if (pix_fire) begin
                o_valid <= 1'b1;
                o_sof   <= sof_armed;
                o_y     <= pix_y;
                o_cb    <= cb_q;
                o_cr    <= pix_cr;
                o_x     <= x_cnt;
                o_line  <= line_cnt;
            end
        end
    end

endmodule
